sv_stream_scoreboard: RTL and testbench
=======================================

Name: sv_stream_scoreboard

Overview:
- Synthesizable in-order scoreboard: the hardware-side consumer of test verdicts.
- A reference-model producer pushes expected words, the DUT output stream delivers actual words; the block compares them beat by beat.
- Keeps passed/failed/skipped counters with per-section skip-after-first-failure semantics, then reports a final verdict.
- Sits at the DUT output boundary in simulation and FPGA self-test benches.

Parameters:
DATA_W, 32, width of expected/actual data words
DEPTH, 8, expected-FIFO depth (power of two, >=2)
CNT_W, 16, width of each result counter
TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
exp_valid  in  1  expected word valid
exp_ready  out  1  expected word accepted (FIFO not full)
exp_data  in  DATA_W  expected word
act_valid  in  1  actual word valid
act_ready  out  1  actual word accepted
act_data  in  DATA_W  actual word
section_start  in  1  one-cycle pulse: begin new test section, clear skip flag
finish  in  1  one-cycle pulse: end of test
passed_cnt  out  CNT_W  matching beats counted
failed_cnt  out  CNT_W  mismatches plus unmatched leftovers
skipped_cnt  out  CNT_W  beats ignored after a failure in the current section
mismatch_pulse  out  1  one-cycle pulse on a counted mismatch
mismatch_exp  out  DATA_W  expected word of the last mismatch
mismatch_act  out  DATA_W  actual word of the last mismatch
done  out  1  final verdict valid, held until reset
verdict_fail  out  1  failed_cnt != 0, valid when done=1
timeout  out  1  watchdog fired (tied 0 without the optional feature)

Behaviour:
- Reset (async, rst_n=0): FIFO empty, state RUN, skip flag 0. All counters, mismatch_*, done, verdict_fail and timeout are 0.
- FIFO and handshakes:
  - exp_ready = !full, from registered occupancy. A pop in the same cycle does not reopen a full FIFO.
  - act_ready = (state==RUN) && !empty. There is no bypass, so an expected word pushed in cycle N can match from cycle N+1 at the earliest.
  - Handshake occurs on valid&&ready; data compared against the FIFO head.
- Compare on act handshake, with results registered one cycle later:
  - Skip flag set: skipped_cnt++ regardless of data.
  - Data equal: passed_cnt++.
  - Data differ: failed_cnt++, skip flag set, mismatch_pulse=1 for exactly one cycle, mismatch_exp/mismatch_act captured and held until the next mismatch.
- Section handling:
  - section_start in the same cycle as a handshake clears the flag before the compare, so that beat belongs to the new section.
  - A mismatch in that beat sets the flag again.
- Counters saturate at 2^CNT_W-1 and never wrap.
- States:
  - RUN --finish--> DRAIN. A handshake in the same cycle as finish is still counted.
  - DRAIN: act_ready=0 and exp_ready=0. Pops one leftover FIFO entry per cycle, failed_cnt++ per entry, no mismatch_pulse. When empty, go to DONE; an empty FIFO spends exactly 1 cycle in DRAIN.
  - DONE: done=1, verdict_fail=(failed_cnt!=0). All inputs ignored, both readys 0, until reset.
- finish while in DRAIN or DONE: ignored.
- Reset asserted mid-operation: immediate return to reset values; FIFO contents are discarded.

Optional Feature:
- SV_SCOREBOARD_TIMEOUT_EN defined:
  - A cycle counter clears on every act handshake and whenever the FIFO is empty, and increments while in RUN with the FIFO non-empty.
  - On reaching TIMEOUT_CYCLES, timeout is set (sticky) and the state moves to DRAIN as if finish had been pulsed.
- Undefined: no counter logic; timeout tied to 0; TIMEOUT_CYCLES unused.

Decomposition:
- Package sv_scoreboard_pkg holds:
  - State enum {ST_RUN, ST_DRAIN, ST_DONE}.
  - Saturating-increment function parameterised by width.
- Sub-module sv_sync_fifo (DATA_W, DEPTH): push/pop, full/empty, registered occupancy, async active-low reset; reusable elsewhere.

Test Plan:
1. Push expected 0x11, 0x22, 0x33; send matching actuals; pulse finish -> passed=3, failed=0, skipped=0, done=1 after 1 DRAIN cycle, verdict_fail=0.
2. Expected 0xA, 0xB, 0xC; actual 0xA, 0xF, 0xC -> passed=1, failed=1, skipped=1, mismatch_pulse once with exp=0xB, act=0xF, verdict_fail=1.
3. After a mismatch, pulse section_start in the same cycle as the next beat, which matches -> that beat counts as passed, not skipped.
4. Push 4 expected, send 1 matching actual, finish -> passed=1, failed=3, done exactly 3 cycles after DRAIN entry.
5. Fill the FIFO to DEPTH=8 -> exp_ready=0; simultaneous push and pop -> push refused that cycle, accepted the next; assert rst_n=0 mid-stream -> all counters 0 and FIFO empty immediately.
6. With SV_SCOREBOARD_TIMEOUT_EN and TIMEOUT_CYCLES=16: push 2 expected, never drive act_valid -> timeout=1 at cycle 16, failed=2, done=1; without the macro, no timeout and done never asserts.

Source files
------------

// File: rtl/sv_scoreboard_pkg.sv
// Shared types and helpers for the stream scoreboard: FSM state encoding and a
// saturating increment used by all result counters.
package sv_scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } sb_state_e;

  // Operates on a 64-bit carrier so any counter width up to 64 can share it.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? max_val : value + 64'd1;
  endfunction

endpackage

// File: rtl/sv_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty derive from the count
// register only, so a same-cycle pop never reopens a full FIFO.
module sv_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sv_stream_scoreboard.sv
// In-order scoreboard comparing a reference stream against DUT output beats.
// Optional watchdog enabled by defining SV_SCOREBOARD_TIMEOUT_EN.
module sv_stream_scoreboard
  import sv_scoreboard_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 8,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [DATA_W-1:0] act_data,
  input  logic              section_start,
  input  logic              finish,
  output logic [CNT_W-1:0]  passed_cnt,
  output logic [CNT_W-1:0]  failed_cnt,
  output logic [CNT_W-1:0]  skipped_cnt,
  output logic              mismatch_pulse,
  output logic [DATA_W-1:0] mismatch_exp,
  output logic [DATA_W-1:0] mismatch_act,
  output logic              done,
  output logic              verdict_fail,
  output logic              timeout
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("sv_stream_scoreboard: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  sb_state_e         state;
  logic              skip_flag;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              exp_hs;
  logic              act_hs;
  logic              to_hit;

  logic [CNT_W-1:0]  passed_nxt;
  logic [CNT_W-1:0]  failed_nxt;
  logic [CNT_W-1:0]  skipped_nxt;
  logic              skip_nxt;
  logic              mismatch_nxt;

  assign exp_ready = (state == ST_RUN) && !fifo_full;
  assign act_ready = (state == ST_RUN) && !fifo_empty;
  assign exp_hs    = exp_valid && exp_ready;
  assign act_hs    = act_valid && act_ready;
  assign fifo_pop  = act_hs || ((state == ST_DRAIN) && !fifo_empty);

  sv_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (exp_hs),
    .push_data (exp_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // section_start clears the flag before the compare so the beat joins the new section.
  always_comb begin
    passed_nxt   = passed_cnt;
    failed_nxt   = failed_cnt;
    skipped_nxt  = skipped_cnt;
    skip_nxt     = skip_flag;
    mismatch_nxt = 1'b0;
    if (state == ST_RUN) begin
      if (section_start) skip_nxt = 1'b0;
      if (act_hs) begin
        if (skip_nxt) begin
          skipped_nxt = CNT_W'(sat_inc(64'(skipped_cnt), CNT_W));
        end else if (act_data == fifo_head) begin
          passed_nxt = CNT_W'(sat_inc(64'(passed_cnt), CNT_W));
        end else begin
          failed_nxt   = CNT_W'(sat_inc(64'(failed_cnt), CNT_W));
          skip_nxt     = 1'b1;
          mismatch_nxt = 1'b1;
        end
      end
    end else if ((state == ST_DRAIN) && !fifo_empty) begin
      failed_nxt = CNT_W'(sat_inc(64'(failed_cnt), CNT_W));
    end
  end

`ifdef SV_SCOREBOARD_TIMEOUT_EN
  logic [31:0] to_cnt;

  assign to_hit = (state == ST_RUN) && !fifo_empty && !act_hs &&
                  (to_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (act_hs || fifo_empty) to_cnt <= '0;
      else if (state == ST_RUN) to_cnt <= to_cnt + 32'd1;
      if (to_hit) timeout <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // The last leftover pop moves straight to DONE, so N leftovers take N DRAIN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      skip_flag      <= 1'b0;
      passed_cnt     <= '0;
      failed_cnt     <= '0;
      skipped_cnt    <= '0;
      mismatch_pulse <= 1'b0;
      mismatch_exp   <= '0;
      mismatch_act   <= '0;
      done           <= 1'b0;
      verdict_fail   <= 1'b0;
    end else begin
      passed_cnt     <= passed_nxt;
      failed_cnt     <= failed_nxt;
      skipped_cnt    <= skipped_nxt;
      skip_flag      <= skip_nxt;
      mismatch_pulse <= mismatch_nxt;
      if (mismatch_nxt) begin
        mismatch_exp <= fifo_head;
        mismatch_act <= act_data;
      end
      case (state)
        ST_RUN: begin
          if (finish || to_hit) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty || fifo_count == CW'(1)) begin
            state        <= ST_DONE;
            done         <= 1'b1;
            verdict_fail <= (failed_nxt != '0);
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sv_stream_scoreboard.sv
// Directed self-checking bench for sv_stream_scoreboard; the watchdog scenario
// follows SV_SCOREBOARD_TIMEOUT_EN.
module tb_sv_stream_scoreboard;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int TO_CYC = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              exp_valid;
  logic              exp_ready;
  logic [DATA_W-1:0] exp_data;
  logic              act_valid;
  logic              act_ready;
  logic [DATA_W-1:0] act_data;
  logic              section_start;
  logic              finish;
  logic [CNT_W-1:0]  passed_cnt;
  logic [CNT_W-1:0]  failed_cnt;
  logic [CNT_W-1:0]  skipped_cnt;
  logic              mismatch_pulse;
  logic [DATA_W-1:0] mismatch_exp;
  logic [DATA_W-1:0] mismatch_act;
  logic              done;
  logic              verdict_fail;
  logic              timeout;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycles;

  always #5 clk = ~clk;

  sv_stream_scoreboard #(
    .DATA_W         (DATA_W),
    .DEPTH          (DEPTH),
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exp_valid      (exp_valid),
    .exp_ready      (exp_ready),
    .exp_data       (exp_data),
    .act_valid      (act_valid),
    .act_ready      (act_ready),
    .act_data       (act_data),
    .section_start  (section_start),
    .finish         (finish),
    .passed_cnt     (passed_cnt),
    .failed_cnt     (failed_cnt),
    .skipped_cnt    (skipped_cnt),
    .mismatch_pulse (mismatch_pulse),
    .mismatch_exp   (mismatch_exp),
    .mismatch_act   (mismatch_act),
    .done           (done),
    .verdict_fail   (verdict_fail),
    .timeout        (timeout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    exp_valid     = 1'b0;
    exp_data      = '0;
    act_valid     = 1'b0;
    act_data      = '0;
    section_start = 1'b0;
    finish        = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d);
    exp_valid = 1'b1;
    exp_data  = d;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic sec);
    act_valid     = 1'b1;
    act_data      = d;
    section_start = sec;
    tick();
    act_valid     = 1'b0;
    section_start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int p, input int f, input int s);
    checkOutput({tag, "_passed"},  32'(passed_cnt),  p);
    checkOutput({tag, "_failed"},  32'(failed_cnt),  f);
    checkOutput({tag, "_skipped"}, 32'(skipped_cnt), s);
  endtask

  initial begin
    do_reset();
    check_counts("rst", 0, 0, 0);
    checkOutput("rst_done",      32'(done),           0);
    checkOutput("rst_verdict",   32'(verdict_fail),   0);
    checkOutput("rst_timeout",   32'(timeout),        0);
    checkOutput("rst_mismatch",  32'(mismatch_pulse), 0);
    checkOutput("rst_exp_ready", 32'(exp_ready),      1);
    checkOutput("rst_act_ready", 32'(act_ready),      0);

    // 1: all beats match
    push_exp(32'h11);
    push_exp(32'h22);
    push_exp(32'h33);
    applyStimulus(32'h11, 1'b0);
    applyStimulus(32'h22, 1'b0);
    applyStimulus(32'h33, 1'b0);
    pulse_finish();
    checkOutput("t1_done_in_drain", 32'(done),      0);
    checkOutput("t1_exp_ready_drn", 32'(exp_ready), 0);
    tick();
    checkOutput("t1_done",    32'(done),         1);
    checkOutput("t1_verdict", 32'(verdict_fail), 0);
    check_counts("t1", 3, 0, 0);
    checkOutput("t1_exp_ready_done", 32'(exp_ready), 0);

    // 2: one mismatch then a skipped beat
    do_reset();
    push_exp(32'hA);
    push_exp(32'hB);
    push_exp(32'hC);
    applyStimulus(32'hA, 1'b0);
    checkOutput("t2_no_pulse_a", 32'(mismatch_pulse), 0);
    applyStimulus(32'hF, 1'b0);
    checkOutput("t2_pulse",   32'(mismatch_pulse), 1);
    checkOutput("t2_mis_exp", mismatch_exp, 32'hB);
    checkOutput("t2_mis_act", mismatch_act, 32'hF);
    applyStimulus(32'hC, 1'b0);
    checkOutput("t2_pulse_once", 32'(mismatch_pulse), 0);
    pulse_finish();
    tick();
    checkOutput("t2_done",    32'(done),         1);
    checkOutput("t2_verdict", 32'(verdict_fail), 1);
    check_counts("t2", 1, 1, 1);

    // 3: section_start on the beat after a mismatch
    do_reset();
    push_exp(32'h1);
    push_exp(32'h2);
    push_exp(32'h3);
    applyStimulus(32'h9, 1'b0);
    applyStimulus(32'h2, 1'b1);
    check_counts("t3a", 1, 1, 0);
    applyStimulus(32'h7, 1'b0);
    check_counts("t3b", 1, 2, 0);
    checkOutput("t3_pulse",   32'(mismatch_pulse), 1);
    checkOutput("t3_mis_exp", mismatch_exp, 32'h3);
    checkOutput("t3_mis_act", mismatch_act, 32'h7);

    // 4: leftovers drained one per cycle
    do_reset();
    for (int i = 1; i <= 4; i++) push_exp(32'(i));
    applyStimulus(32'h1, 1'b0);
    pulse_finish();
    checkOutput("t4_act_ready_drain", 32'(act_ready), 0);
    cycles = 0;
    while (!done && cycles < 10) begin
      tick();
      cycles++;
    end
    checkOutput("t4_drain_cycles", 32'(cycles), 3);
    checkOutput("t4_verdict", 32'(verdict_fail), 1);
    check_counts("t4", 1, 3, 0);

    // 5: full FIFO, push refused during same-cycle pop, async reset
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_exp(32'h100 + 32'(i));
    checkOutput("t5_full_exp_ready", 32'(exp_ready), 0);
    checkOutput("t5_full_act_ready", 32'(act_ready), 1);
    exp_valid = 1'b1;
    exp_data  = 32'h200;
    act_valid = 1'b1;
    act_data  = 32'h100;
    tick();
    act_valid = 1'b0;
    checkOutput("t5_reopen", 32'(exp_ready), 1);
    tick();
    exp_valid = 1'b0;
    checkOutput("t5_refilled", 32'(exp_ready),  0);
    checkOutput("t5_passed",   32'(passed_cnt), 1);
    rst_n = 1'b0;
    #1;
    check_counts("t5_async_rst", 0, 0, 0);
    checkOutput("t5_rst_act_ready", 32'(act_ready), 0);
    checkOutput("t5_rst_exp_ready", 32'(exp_ready), 1);
    tick();
    rst_n = 1'b1;

    // saturation of a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) begin
      push_exp(32'h40 + 32'(i));
      applyStimulus(32'h40 + 32'(i), 1'b0);
    end
    check_counts("sat", 15, 0, 0);

    // 6: nothing arrives on the actual stream
    do_reset();
    push_exp(32'h55);
    push_exp(32'h66);
    cycles = 1;
`ifdef SV_SCOREBOARD_TIMEOUT_EN
    while (!timeout && cycles < 40) begin
      tick();
      cycles++;
    end
    checkOutput("t6_timeout_cycle", 32'(cycles), TO_CYC);
    checkOutput("t6_timeout", 32'(timeout), 1);
    cycles = 0;
    while (!done && cycles < 10) begin
      tick();
      cycles++;
    end
    checkOutput("t6_done",    32'(done),         1);
    checkOutput("t6_verdict", 32'(verdict_fail), 1);
    check_counts("t6", 0, 2, 0);
`else
    while (cycles < 40) begin
      tick();
      cycles++;
    end
    checkOutput("t6_no_timeout", 32'(timeout),   0);
    checkOutput("t6_no_done",    32'(done),      0);
    checkOutput("t6_act_ready",  32'(act_ready), 1);
    check_counts("t6", 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
